byte_unstriping: RTL and testbench
==================================

BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 Parameter: DEPTH, default 4, entries per lane FIFO; power of two, minimum 2.
REQ-002 Port: clk_2f, input, 1, single clock; every register updates on its rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: lane_0, input, 8, lane 0 byte; carries even-indexed bytes of the original stream.
REQ-005 Port: valid_0, input, 1, lane_0 holds a byte this cycle.
REQ-006 Port: lane_1, input, 8, lane 1 byte; carries odd-indexed bytes of the original stream.
REQ-007 Port: valid_1, input, 1, lane_1 holds a byte this cycle.
REQ-008 Port: data_out, output, 8, reassembled byte stream, registered.
REQ-009 Port: valid_out, output, 1, data_out is valid this cycle, registered.
REQ-010 Port: err, output, 1, sticky lane-overflow flag; exists only when BYTE_UNSTRIPING_ERR_EN is defined.

Function
REQ-011 Each lane SHALL have its own DEPTH-entry FIFO; a byte is written on any rising edge where its valid is high and the write is accepted.
REQ-012 A write SHALL be accepted when count < DEPTH, or when count == DEPTH and the same FIFO is read in the same cycle.
REQ-013 A write that is not accepted SHALL be dropped, and FIFO contents SHALL be left unchanged.
REQ-014 Both lanes SHALL be writable in the same cycle, independently of each other.
REQ-015 A 1-bit selector sel SHALL reset to 0 (lane 0). Each cycle:
- If FIFO[sel] is non-empty, its head SHALL be popped and registered into data_out, valid_out SHALL go to 1, and sel SHALL toggle.
- Otherwise valid_out SHALL go to 0, and sel and data_out SHALL hold.
REQ-016 Output order SHALL be strict alternation L0, L1, L0, L1, ...; the block SHALL never skip the selected lane to serve the other lane.
REQ-017 Latency: a byte written at edge k into an empty, selected FIFO SHALL appear on data_out with valid_out=1 after edge k+1; there is no write-to-read bypass within a cycle.
REQ-018 Sustained throughput SHALL be one byte per clk_2f cycle, provided lane arrivals are balanced.
REQ-019 FIFO pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and the count SHALL be log2(DEPTH)+1 bits.
REQ-020 A simultaneous pop and push on the same FIFO SHALL leave count unchanged.

Reset
REQ-021 While reset is high at a rising edge, both FIFOs SHALL empty (pointers and counts 0), sel SHALL go to 0, data_out SHALL go to 8'h00, valid_out SHALL go to 0, and err SHALL go to 0.
REQ-022 Reset asserted mid-stream SHALL discard all buffered bytes, and lane inputs sampled during reset SHALL be ignored.
REQ-023 The first valid lane_0 byte after reset deassertion SHALL be the first byte output.

Configuration
REQ-024 With BYTE_UNSTRIPING_ERR_EN defined, err SHALL be set on the edge after any rejected write on either lane and SHALL hold until reset.
REQ-025 Without BYTE_UNSTRIPING_ERR_EN, the err port and its logic SHALL be absent, and rejected writes SHALL drop silently.

Structure
REQ-026 The shared package byte_stripe_pkg SHALL hold: LANE_W = 8, NUM_LANES = 2, the default DEPTH constant, and the lane-select enum LANE0/LANE1.
REQ-027 The per-lane buffer SHALL be a sub-module, lane_fifo, instantiated twice; the top level contains only the selector and the output register.

Verification
REQ-028 Balanced stream: each cycle, valid_0=valid_1=1 with lane_0 = 00,02,04 and lane_1 = 01,03,05 -> data_out = 00,01,02,03,04,05 with valid_out continuous, first byte one cycle after first write.
REQ-029 Lane 1 late: lane_0 = AA at cycle 0, lane_1 = BB at cycle 3 -> AA output at cycle 1, valid_out=0 for cycles 2-3, BB output at cycle 4.
REQ-030 Lane 1 only after reset: lane_1 = 55 with valid_1=1 for 3 cycles and no lane 0 traffic -> valid_out stays 0 (sel remains on lane 0); with DEPTH=4, no drop occurs.
REQ-031 Overflow (ERR_EN defined, DEPTH=4): 5 lane_1 bytes 10..14 with no lane 0 traffic -> 14 dropped, err=1 the next cycle; later lane_0 = 20 -> output 20,10,... and 14 never appears.
REQ-032 Mid-stream reset: reset=1 for one cycle while both FIFOs hold 2 bytes -> next cycle valid_out=0 and data_out=00; the following lane_0 = 77, lane_1 = 88 -> output 77 then 88.
REQ-033 Full FIFO with simultaneous pop: lane_0 FIFO full (4 bytes), sel=0, new lane_0 byte pushed in the same cycle -> write accepted, count stays 4, err stays 0.

Source files
------------

// File: rtl/byte_stripe_pkg.sv
// Shared constants and lane-select type for the byte striping/unstriping blocks.
package byte_stripe_pkg;

    localparam int unsigned LANE_W        = 8;
    localparam int unsigned NUM_LANES     = 2;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_sel_e;

endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// Per-lane byte FIFO: power-of-two depth, full-with-pop write acceptance,
// combinational head and drop indication for the selector above it.
module lane_fifo
    import byte_stripe_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [LANE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [LANE_W-1:0] o_head_c,
    output logic              o_empty_c,
    output logic              o_drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [LANE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    // A full FIFO still takes a write when its head leaves on the same edge.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == CNT_W'(0));
    assign w_pop     = i_rd_en & ~o_empty_c;
    assign w_push    = i_wr_en & (~w_full | w_pop);
    assign o_drop_c  = i_wr_en & ~w_push;
    assign o_head_c  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/byte_unstriping.sv
// Two-lane byte unstriper: strict L0/L1 alternating merge of two lane FIFOs.
// Optional sticky overflow flag 'err' is built when BYTE_UNSTRIPING_ERR_EN is defined.
module byte_unstriping
    import byte_stripe_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [LANE_W-1:0] lane_0,
    input  logic              valid_0,
    input  logic [LANE_W-1:0] lane_1,
    input  logic              valid_1,
    output logic [LANE_W-1:0] data_out,
    output logic              valid_out
`ifdef BYTE_UNSTRIPING_ERR_EN
    ,
    output logic              err
`endif
);

    lane_sel_e         r_sel;
    logic [LANE_W-1:0] r_data_out;
    logic              r_valid_out;

    logic [LANE_W-1:0] w_head_0;
    logic [LANE_W-1:0] w_head_1;
    logic              w_empty_0;
    logic              w_empty_1;
    logic              w_rd_0;
    logic              w_rd_1;
    logic              w_avail;
    logic [LANE_W-1:0] w_head_sel;
`ifdef BYTE_UNSTRIPING_ERR_EN
    logic              w_drop_0;
    logic              w_drop_1;
    logic              r_err;
`endif

    // Only the selected lane is ever read; the other lane is never served early.
    assign w_rd_0     = (r_sel == LANE0);
    assign w_rd_1     = (r_sel == LANE1);
    assign w_avail    = w_rd_0 ? ~w_empty_0 : ~w_empty_1;
    assign w_head_sel = w_rd_0 ? w_head_0 : w_head_1;

    lane_fifo #(.DEPTH(DEPTH)) u_fifo_0 (
        .clk       (clk_2f),
        .reset     (reset),
        .i_wr_en   (valid_0),
        .i_wr_data (lane_0),
        .i_rd_en   (w_rd_0),
        .o_head_c  (w_head_0),
        .o_empty_c (w_empty_0),
`ifdef BYTE_UNSTRIPING_ERR_EN
        .o_drop_c  (w_drop_0)
`else
        .o_drop_c  ()
`endif
    );

    lane_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk       (clk_2f),
        .reset     (reset),
        .i_wr_en   (valid_1),
        .i_wr_data (lane_1),
        .i_rd_en   (w_rd_1),
        .o_head_c  (w_head_1),
        .o_empty_c (w_empty_1),
`ifdef BYTE_UNSTRIPING_ERR_EN
        .o_drop_c  (w_drop_1)
`else
        .o_drop_c  ()
`endif
    );

    // Selector and output register: pop and toggle only when the selected lane has data.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_sel       <= LANE0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else if (w_avail) begin
            r_sel       <= (r_sel == LANE0) ? LANE1 : LANE0;
            r_data_out  <= w_head_sel;
            r_valid_out <= 1'b1;
        end else begin
            r_valid_out <= 1'b0;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

`ifdef BYTE_UNSTRIPING_ERR_EN
    // Sticky until reset once either lane rejects a write.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_drop_0 || w_drop_1) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed self-checking bench for byte_unstriping (DEPTH = 4); err checks
// are compiled in when BYTE_UNSTRIPING_ERR_EN is defined.
`timescale 1ns/1ps
module tb_byte_unstriping;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] lane_0;
    logic       valid_0;
    logic [7:0] lane_1;
    logic       valid_1;
    logic [7:0] data_out;
    logic       valid_out;
`ifdef BYTE_UNSTRIPING_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int passes = 0;

    byte_unstriping #(.DEPTH(4)) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .lane_0    (lane_0),
        .valid_0   (valid_0),
        .lane_1    (lane_1),
        .valid_1   (valid_1),
        .data_out  (data_out),
        .valid_out (valid_out)
`ifdef BYTE_UNSTRIPING_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1ns after an edge and outputs checked 1ns after the next.
    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        chk({tag, ".valid"}, 8'(valid_out), 8'h01);
        chk({tag, ".data"}, data_out, exp);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".valid"}, 8'(valid_out), 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        tick();
        expect_idle("reset");
        chk("reset.data", data_out, 8'h00);
`ifdef BYTE_UNSTRIPING_ERR_EN
        chk("reset.err", 8'(err), 8'h00);
`endif
        reset = 1'b0;

        // Balanced stream
        drive(1'b1, 8'h00, 1'b1, 8'h01); tick(); expect_idle("bal.lat");
        drive(1'b1, 8'h02, 1'b1, 8'h03); tick(); expect_byte("bal0", 8'h00);
        drive(1'b1, 8'h04, 1'b1, 8'h05); tick(); expect_byte("bal1", 8'h01);
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("bal2", 8'h02);
        tick(); expect_byte("bal3", 8'h03);
        tick(); expect_byte("bal4", 8'h04);
        tick(); expect_byte("bal5", 8'h05);
        tick(); expect_idle("bal.end");

        // Lane 1 late: no skipping of the selected lane
        drive(1'b1, 8'hAA, 1'b0, 8'h00); tick(); expect_idle("late.c0");
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("late.c1", 8'hAA);
        tick(); expect_idle("late.c2");
        chk("late.c2.hold", data_out, 8'hAA);
        drive(1'b0, 8'h00, 1'b1, 8'hBB); tick(); expect_idle("late.c3");
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("late.c4", 8'hBB);

        // Lane 1 only: sel stays on lane 0, three bytes fit without a drop
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_idle("l1only");
        end
`ifdef BYTE_UNSTRIPING_ERR_EN
        chk("l1only.err", 8'(err), 8'h00);
`endif
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        reset = 1'b1; tick(); reset = 1'b0;
        expect_idle("rst2");

        // Overflow of lane 1: 14 is dropped
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(8'h10 + i));
            tick(); expect_idle("ovf.fill");
        end
`ifdef BYTE_UNSTRIPING_ERR_EN
        chk("ovf.err", 8'(err), 8'h01);
`endif
        drive(1'b1, 8'h20, 1'b0, 8'h00); tick(); expect_idle("ovf.w20");
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("ovf.o20", 8'h20);
        tick(); expect_byte("ovf.o10", 8'h10);
        tick(); expect_idle("ovf.gap");
        drive(1'b1, 8'h21, 1'b0, 8'h00); tick(); expect_idle("ovf.w21");
        drive(1'b1, 8'h22, 1'b0, 8'h00); tick(); expect_byte("ovf.o21", 8'h21);
        drive(1'b1, 8'h23, 1'b0, 8'h00); tick(); expect_byte("ovf.o11", 8'h11);
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("ovf.o22", 8'h22);
        tick(); expect_byte("ovf.o12", 8'h12);
        tick(); expect_byte("ovf.o23", 8'h23);
        tick(); expect_byte("ovf.o13", 8'h13);
        tick(); expect_idle("ovf.no14");
`ifdef BYTE_UNSTRIPING_ERR_EN
        chk("ovf.err.sticky", 8'(err), 8'h01);
`endif

        // Mid-stream reset with two bytes buffered per lane
        drive(1'b1, 8'hA1, 1'b1, 8'hB1); tick(); expect_idle("mid.w1");
        drive(1'b1, 8'hA2, 1'b1, 8'hB2); tick(); expect_byte("mid.a1", 8'hA1);
        drive(1'b1, 8'hA3, 1'b1, 8'hB3); tick(); expect_byte("mid.b1", 8'hB1);
        drive(1'b1, 8'hEE, 1'b1, 8'hEE);
        reset = 1'b1; tick(); reset = 1'b0;
        expect_idle("mid.rst");
        chk("mid.rst.data", data_out, 8'h00);
`ifdef BYTE_UNSTRIPING_ERR_EN
        chk("mid.rst.err", 8'(err), 8'h00);
`endif
        drive(1'b1, 8'h77, 1'b1, 8'h88); tick(); expect_idle("mid.w77");
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("mid.o77", 8'h77);
        tick(); expect_byte("mid.o88", 8'h88);
        tick(); expect_idle("mid.end");

        // Full lane 0 FIFO accepts a write on the edge its head is popped
        drive(1'b1, 8'hD0, 1'b0, 8'h00); tick(); expect_idle("full.wD0");
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("full.oD0", 8'hD0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 8'h00);
            tick(); expect_idle("full.fill");
        end
        drive(1'b0, 8'h00, 1'b1, 8'hE0); tick(); expect_idle("full.wE0");
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("full.oE0", 8'hE0);
        drive(1'b1, 8'hC4, 1'b1, 8'hE1); tick(); expect_byte("full.oC0", 8'hC0);
`ifdef BYTE_UNSTRIPING_ERR_EN
        chk("full.err", 8'(err), 8'h00);
`endif
        drive(1'b0, 8'h00, 1'b1, 8'hE2); tick(); expect_byte("full.oE1", 8'hE1);
        drive(1'b0, 8'h00, 1'b1, 8'hE3); tick(); expect_byte("full.oC1", 8'hC1);
        drive(1'b0, 8'h00, 1'b1, 8'hE4); tick(); expect_byte("full.oE2", 8'hE2);
        drive(1'b0, 8'h00, 1'b0, 8'h00); tick(); expect_byte("full.oC2", 8'hC2);
        tick(); expect_byte("full.oE3", 8'hE3);
        tick(); expect_byte("full.oC3", 8'hC3);
        tick(); expect_byte("full.oE4", 8'hE4);
        tick(); expect_byte("full.oC4", 8'hC4);
        tick(); expect_idle("full.end");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
